// File: rtl/booth_mac_if.sv
// Handshake bundle for booth_mac: job start, operand stream and result port.
// The master side drives jobs and operands; the slave side is the MAC stage.
interface booth_mac_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic                    start;
    logic [CNT_W-1:0]        len;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [7:0]       a;
    logic signed [7:0]       b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] acc_out;
    logic                    sat;
    logic                    err;
    logic                    busy;

    modport master (
        output start, len, in_valid, a, b, out_ready,
        input  in_ready, out_valid, acc_out, sat, err, busy
    );

    modport slave (
        input  start, len, in_valid, a, b, out_ready,
        output in_ready, out_valid, acc_out, sat, err, busy
    );
endinterface

// File: rtl/booth_mac.sv
// Streaming signed multiply-accumulate: operand regs -> radix-4 Booth multiply ->
// product reg -> saturating accumulator, with a job length and a held result.
module booth_mac #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    booth_mac_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Radix-4 modified Booth product; a = -128 is excluded by the caller.
    function automatic logic signed [15:0] booth_mul(input logic signed [7:0] x,
                                                     input logic signed [7:0] y);
        logic [8:0]         yb;
        logic signed [15:0] xe;
        logic signed [15:0] pp;
        logic signed [15:0] sum;
        yb  = {y, 1'b0};
        xe  = {{8{x[7]}}, x};
        sum = 16'sd0;
        for (int i = 0; i < 4; i++) begin
            case (yb[2*i +: 3])
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe <<< 1;
                3'b100:         pp = -(xe <<< 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = 16'sd0;
            endcase
            sum = sum + (pp <<< (2*i));
        end
        return sum;
    endfunction

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        rem_r;
    logic                    op_v_r, prod_v_r;
    logic signed [7:0]       op_a_r, op_b_r;
    logic signed [15:0]      prod_r, mul_s;
    logic signed [ACC_W-1:0] acc_r, acc_s;
    logic [ACC_W:0]          sum_s;
    logic                    ovf_s;
    logic                    sat_r, err_r, in_ready_r, out_valid_r, busy_r;
    logic                    fire_s, last_s, start_ok_s;

    assign fire_s     = bus.in_valid && in_ready_r;
    assign last_s     = fire_s && (rem_r == CNT_W'(1));
    assign start_ok_s = (state_r == IDLE) && bus.start;
    assign mul_s      = ($unsigned(op_a_r) == 8'h80) ? 16'sd0 : booth_mul(op_a_r, op_b_r);

    // Next-state logic; DRAIN exits on the edge that retires the last product.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) state_s = DONE;
                    else               state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) state_s = DRAIN;
                else        state_s = RUN;
            end
            DRAIN: begin
                if (!op_v_r) state_s = DONE;
                else         state_s = DRAIN;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Saturating add of the sign-extended product at ACC_W+1 bits.
    always_comb begin
        sum_s = {acc_r[ACC_W-1], acc_r} + {{(ACC_W+1-16){prod_r[15]}}, prod_r};
        ovf_s = 1'b0;
        acc_s = sum_s[ACC_W-1:0];
        if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
            ovf_s = 1'b1;
            if (sum_s[ACC_W]) acc_s = {1'b1, {(ACC_W-1){1'b0}}};
            else              acc_s = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Datapath, sticky flags and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= '0;
            op_v_r      <= 1'b0;
            prod_v_r    <= 1'b0;
            op_a_r      <= 8'sd0;
            op_b_r      <= 8'sd0;
            prod_r      <= 16'sd0;
            acc_r       <= '0;
            sat_r       <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            op_v_r   <= fire_s;
            prod_v_r <= op_v_r;
            if (fire_s) begin
                op_a_r <= bus.a;
                op_b_r <= bus.b;
            end
            if (op_v_r) prod_r <= mul_s;
            if (start_ok_s) begin
                acc_r <= '0;
                sat_r <= 1'b0;
                err_r <= 1'b0;
                rem_r <= bus.len;
            end else begin
                if (fire_s) begin
                    rem_r <= rem_r - CNT_W'(1);
                    if ($unsigned(bus.a) == 8'h80) err_r <= 1'b1;
                end
                if (prod_v_r) begin
                    acc_r <= acc_s;
                    if (ovf_s) sat_r <= 1'b1;
                end
            end
            in_ready_r  <= (state_s == RUN);
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.acc_out   = acc_r;
    assign bus.sat       = sat_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_booth_mac.sv
// Scoreboard bench for booth_mac (ACC_W=16 so saturation is reachable with 8x8 products).
module tb_booth_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mac_if #(.ACC_W(16), .CNT_W(8)) bus ();
    booth_mac #(.ACC_W(16), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        longint acc;
        longint sat;
        longint err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   hs_cnt = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input longint acc, input longint s, input longint e);
        exp_t x;
        x.acc = acc;
        x.sat = s;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic start_job(input int n);
        bus.start = 1'b1;
        bus.len   = 8'(n);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int x, input int y);
        int t = 0;
        while (!bus.in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready_wait", longint'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a = 8'(x);
        bus.b = 8'(y);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the last accept until out_valid rises.
    task automatic wait_out(input string nm, input int lat);
        int c = 0;
        while (!bus.out_valid && c < 20) begin
            tick();
            c++;
        end
        chk(nm, c, lat);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_in_ready"}, longint'(bus.in_ready), 0);
        chk({nm, "_out_valid"}, longint'(bus.out_valid), 0);
        chk({nm, "_acc_out"}, longint'(bus.acc_out), 0);
        chk({nm, "_sat"}, longint'(bus.sat), 0);
        chk({nm, "_err"}, longint'(bus.err), 0);
        chk({nm, "_busy"}, longint'(bus.busy), 0);
    endtask

    // Monitor: every cycle a result is shown it must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("acc_out", longint'(bus.acc_out), exp_q[0].acc);
                    chk("sat", longint'(bus.sat), exp_q[0].sat);
                    chk("err", longint'(bus.err), exp_q[0].err);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.len = 8'd0;
        bus.in_valid = 1'b0;
        bus.a = 8'sd0;
        bus.b = 8'sd0;
        bus.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        #22;
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", longint'(bus.busy), 0);
        chk("post_rst_in_ready", longint'(bus.in_ready), 0);

        // Back-to-back signed products
        expect_result(-16208, 0, 0);
        start_job(3);
        chk("start_in_ready", longint'(bus.in_ready), 1);
        chk("start_busy", longint'(bus.busy), 1);
        send(3, -5);
        send(-7, -9);
        send(127, -128);
        wait_out("lat_b2b", 2);
        tick();

        // Gaps and slow consumer; a start during DONE and at the handshake is ignored
        bus.out_ready = 1'b0;
        expect_result(92, 0, 0);
        start_job(2);
        send(10, 10);
        repeat (3) tick();
        send(-2, 4);
        wait_out("lat_gap", 2);
        bus.start = 1'b1;
        bus.len = 8'd1;
        repeat (5) tick();
        chk("done_hold_valid", longint'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("handoff_busy", longint'(bus.busy), 0);
        chk("handoff_valid", longint'(bus.out_valid), 0);
        tick();
        chk("no_queued_start", longint'(bus.busy), 0);
        chk("hs_after_slow", hs_cnt, 2);

        // Positive saturation, then flags clear on the next job
        expect_result(32767, 1, 0);
        start_job(3);
        send(127, 127);
        send(127, 127);
        send(127, 127);
        wait_out("lat_sat", 2);
        tick();
        expect_result(1, 0, 0);
        start_job(1);
        send(1, 1);
        wait_out("lat_one", 2);
        tick();

        // Negative saturation
        expect_result(-32768, 1, 0);
        start_job(3);
        send(-127, 127);
        send(-127, 127);
        send(-127, 127);
        wait_out("lat_negsat", 2);
        tick();

        // a = -128 substitutes a zero product and flags err
        expect_result(6, 0, 1);
        start_job(2);
        send(-128, 5);
        send(2, 3);
        wait_out("lat_err", 2);
        tick();

        // len = 0 completes right after the start edge
        expect_result(0, 0, 0);
        start_job(0);
        chk("len0_valid", longint'(bus.out_valid), 1);
        tick();

        // Reset mid-job: no result, outputs back to reset values
        start_job(4);
        send(5, 5);
        send(6, 6);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("midrst_no_valid", longint'(bus.out_valid), 0);
        chk("midrst_busy", longint'(bus.busy), 0);

        chk("queue_empty", exp_q.size(), 0);
        chk("handshakes", hs_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
